// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Definitions shared by the instruction-fetch slice: the default datapath
// width, the fetch-queue depth and the sequencer state encoding.
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam int FETCH_WIDTH = 32;
    localparam int QUEUE_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // one settling cycle after reset, no request
        ST_ISSUE = 2'd1,  // queue full, request held back
        ST_WAIT  = 2'd2,  // request to pc outstanding
        ST_DROP  = 2'd3   // stale request outstanding, its data is discarded
    } fetch_state_e;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Request/ready handshake between the fetch sequencer and instruction memory.
//   imem_req   : master -> slave, fetch request, held until imem_ready
//   imem_addr  : master -> slave, fetch address, stable while imem_req=1
//   imem_ready : slave -> master, one-cycle pulse, imem_rdata valid
//   imem_rdata : slave -> master, instruction word
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int WIDTH = 32
) ();

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;
    logic [WIDTH-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);

endinterface : fetch_ctrl_if

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Two-entry FIFO of {instruction, pc+4} pairs feeding the IF/ID boundary.
//   clk, rst   : clock, synchronous active-low reset
//   clear      : drop every entry (dominates push and pop)
//   push       : write push_instr/push_pc at the tail (caller guarantees space)
//   pop        : retire the head entry (caller guarantees valid)
//   valid      : head entry present
//   count      : number of entries held, 0..2
//   head_instr : head instruction
//   head_pc    : head pc+4
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = FETCH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_instr,
    input  logic [WIDTH-1:0] push_pc,
    output logic             valid,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_instr,
    output logic [WIDTH-1:0] head_pc
);

    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] instr_q [QUEUE_DEPTH];
    logic [WIDTH-1:0] instr_d [QUEUE_DEPTH];
    logic [WIDTH-1:0] pc_q    [QUEUE_DEPTH];
    logic [WIDTH-1:0] pc_d    [QUEUE_DEPTH];

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                instr_d[tail_q] = push_instr;
                pc_d[tail_q]    = push_pc;
                tail_d          = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, regardless of statement order.
        if (!rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            // NOTE: the entry storage is reset too because the head is
            // visible on the outputs and must read as zero after reset.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid      = (count_q != 2'd0);
    assign count      = count_q;
    assign head_instr = instr_q[head_q];
    assign head_pc    = pc_q[head_q];

endmodule : fetch_queue

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer: owns the program counter, drives the
// instruction memory handshake, buffers responses in a 2-entry queue and
// applies decode-stage redirects, discarding any stale in-flight response.
//   clk, rst     : clock, synchronous active-low reset
//   stall_decode : decode cannot take the head instruction this cycle
//   jump_decode  : jump resolved in decode (wins over a branch)
//   pcsrc_decode : taken branch resolved in decode
//   pc_jump      : jump target
//   pc_branch    : branch target
//   imem         : instruction memory handshake (master side)
//   fetch_valid  : queue head valid
//   instr_fetch  : head instruction
//   pc_fetch     : head pc+4
//   flush_decode : redirect accepted this cycle, clear IF/ID
// ---------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int               WIDTH    = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_decode,
    input  logic             jump_decode,
    input  logic             pcsrc_decode,
    input  logic [WIDTH-1:0] pc_jump,
    input  logic [WIDTH-1:0] pc_branch,
    fetch_ctrl_if.master     imem,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] instr_fetch,
    output logic [WIDTH-1:0] pc_fetch,
    output logic             flush_decode
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             push;
    logic             pop;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic [WIDTH-1:0] pc_plus4;

    // IDLE is the settling cycle after reset; a redirect there is not taken.
    assign redirect = (jump_decode | pcsrc_decode) & ~stall_decode
                    & (state_q != ST_IDLE);
    assign target   = jump_decode ? pc_jump : pc_branch;
    assign pc_plus4 = pc_q + WIDTH'(4);

    assign push = (state_q == ST_WAIT) & imem.imem_ready & ~redirect;
    assign pop  = fetch_valid & ~stall_decode & ~redirect;

    // Occupancy after this edge; a redirect empties the queue outright.
    assign count_next = redirect ? 2'd0 : (count + 2'(push) - 2'(pop));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT;
            end
            ST_ISSUE: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_WAIT;
                end else if ((count < 2'(QUEUE_DEPTH)) || pop) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    if (imem.imem_ready) begin
                        pc_d = target;
                    end else begin
                        // The request in flight cannot be withdrawn: park the
                        // target until the stale response has drained.
                        pend_d  = target;
                        state_d = ST_DROP;
                    end
                end else if (imem.imem_ready) begin
                    pc_d    = pc_plus4;
                    // The next request may only go out if its response is
                    // guaranteed a free queue slot.
                    state_d = (count_next < 2'(QUEUE_DEPTH)) ? ST_WAIT : ST_ISSUE;
                end
            end
            ST_DROP: begin
                if (imem.imem_ready) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = ST_WAIT;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    fetch_queue #(
        .WIDTH (WIDTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect),
        .push       (push),
        .pop        (pop),
        .push_instr (imem.imem_rdata),
        .push_pc    (pc_plus4),
        .valid      (fetch_valid),
        .count      (count),
        .head_instr (instr_fetch),
        .head_pc    (pc_fetch)
    );

    // In DROP pc still holds the stale address, so the address stays stable.
    assign imem.imem_req  = (state_q == ST_WAIT) || (state_q == ST_DROP);
    assign imem.imem_addr = pc_q;
    assign flush_decode   = redirect;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 time unit later. The memory returns a fixed
// address-derived word so every expected instruction is known up front.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         stall_decode;
    logic         jump_decode;
    logic         pcsrc_decode;
    logic [W-1:0] pc_jump;
    logic [W-1:0] pc_branch;
    logic         ready;
    logic         fetch_valid;
    logic [W-1:0] instr_fetch;
    logic [W-1:0] pc_fetch;
    logic         flush_decode;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl_if #(.WIDTH(W)) imem ();

    function automatic logic [W-1:0] rd(input logic [W-1:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem.imem_ready = ready;
    assign imem.imem_rdata = rd(imem.imem_addr);

    fetch_ctrl #(
        .WIDTH    (W),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_decode (stall_decode),
        .jump_decode  (jump_decode),
        .pcsrc_decode (pcsrc_decode),
        .pc_jump      (pc_jump),
        .pc_branch    (pc_branch),
        .imem         (imem),
        .fetch_valid  (fetch_valid),
        .instr_fetch  (instr_fetch),
        .pc_fetch     (pc_fetch),
        .flush_decode (flush_decode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_bus(input string tag, input logic req, input logic [W-1:0] addr);
        check({tag, "_req"}, W'(imem.imem_req), W'(req));
        check({tag, "_addr"}, imem.imem_addr, addr);
    endtask

    task automatic expect_head(input string tag, input logic v, input logic [W-1:0] pcf,
                               input logic [W-1:0] ins);
        check({tag, "_valid"}, W'(fetch_valid), W'(v));
        check({tag, "_pc"}, pc_fetch, pcf);
        check({tag, "_instr"}, instr_fetch, ins);
    endtask

    initial begin
        rst          = 1'b0;
        stall_decode = 1'b0;
        jump_decode  = 1'b0;
        pcsrc_decode = 1'b0;
        pc_jump      = '0;
        pc_branch    = '0;
        ready        = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        expect_bus("rst", 1'b0, 32'h0);
        expect_head("rst", 1'b0, 32'h0, 32'h0);
        check("rst_flush", W'(flush_decode), 32'h0);

        // Zero-wait memory, 1 instruction per cycle
        rst = 1'b1; ready = 1'b1; #1;
        check("idle_req", W'(imem.imem_req), 32'h0);
        @(negedge clk); #1;
        expect_bus("t1_first", 1'b1, 32'h0);
        check("t1_empty", W'(fetch_valid), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #1;
            expect_bus("t1_seq", 1'b1, W'(4 * i));
            expect_head("t1_head", 1'b1, W'(4 * i), rd(W'(4 * (i - 1))));
        end

        // Stall for 5 cycles: queue fills, request held back
        @(negedge clk); stall_decode = 1'b1; #1;
        expect_bus("t2_s0", 1'b1, 32'h10);
        expect_head("t2_s0", 1'b1, 32'h10, rd(32'hC));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            expect_bus("t2_full", 1'b0, 32'h14);
            expect_head("t2_full", 1'b1, 32'h10, rd(32'hC));
        end
        @(negedge clk); stall_decode = 1'b0; #1;
        expect_bus("t2_rel", 1'b0, 32'h14);
        @(negedge clk); #1;
        expect_bus("t2_resume", 1'b1, 32'h14);
        expect_head("t2_resume", 1'b1, 32'h14, rd(32'h10));
        @(negedge clk); #1;
        expect_bus("t2_next", 1'b1, 32'h18);
        expect_head("t2_next", 1'b1, 32'h18, rd(32'h14));

        // Reset from WAIT with a full pipe, then 3-cycle latency memory
        @(negedge clk); rst = 1'b0; ready = 1'b0; #1;
        @(negedge clk); #1;
        expect_bus("t3_rst", 1'b0, 32'h0);
        expect_head("t3_rst", 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        for (int a = 0; a < 8; a += 4) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk); ready = (k == 2); #1;
                expect_bus("t3_hold", 1'b1, W'(a));
            end
        end
        @(negedge clk); ready = 1'b0; #1;
        expect_bus("t3_w8", 1'b1, 32'h8);
        expect_head("t3_w8", 1'b1, 32'h8, rd(32'h4));
        // Branch one cycle into WAIT for 0x8
        @(negedge clk); pcsrc_decode = 1'b1; pc_branch = 32'h40; #1;
        check("t3_flush", W'(flush_decode), 32'h1);
        expect_bus("t3_br", 1'b1, 32'h8);
        @(negedge clk); pcsrc_decode = 1'b0; #1;
        check("t3_noflush", W'(flush_decode), 32'h0);
        expect_bus("t3_drop", 1'b1, 32'h8);
        @(negedge clk); ready = 1'b1; #1;
        expect_bus("t3_stale", 1'b1, 32'h8);
        @(negedge clk); #1;
        expect_bus("t3_target", 1'b1, 32'h40);
        check("t3_discard", W'(fetch_valid), 32'h0);

        // Jump and branch together, with a response in the same cycle
        @(negedge clk);
        jump_decode = 1'b1; pcsrc_decode = 1'b1;
        pc_jump = 32'h100; pc_branch = 32'h40; #1;
        check("t4_flush", W'(flush_decode), 32'h1);
        expect_bus("t4_br", 1'b1, 32'h44);
        expect_head("t4_br", 1'b1, 32'h44, rd(32'h40));
        @(negedge clk); jump_decode = 1'b0; pcsrc_decode = 1'b0; #1;
        expect_bus("t4_jump", 1'b1, 32'h100);
        check("t4_cleared", W'(fetch_valid), 32'h0);

        // Two redirects while a stale request drains: the later one wins
        @(negedge clk); ready = 1'b0; pcsrc_decode = 1'b1; pc_branch = 32'h200; #1;
        check("t5_flush1", W'(flush_decode), 32'h1);
        expect_bus("t5_w", 1'b1, 32'h104);
        expect_head("t5_w", 1'b1, 32'h104, rd(32'h100));
        @(negedge clk); pcsrc_decode = 1'b0; jump_decode = 1'b1; pc_jump = 32'h300; #1;
        check("t5_flush2", W'(flush_decode), 32'h1);
        expect_bus("t5_drop", 1'b1, 32'h104);
        check("t5_cleared", W'(fetch_valid), 32'h0);
        @(negedge clk); jump_decode = 1'b0; ready = 1'b1; #1;
        expect_bus("t5_stale", 1'b1, 32'h104);
        @(negedge clk); ready = 1'b0; #1;
        expect_bus("t5_latest", 1'b1, 32'h300);
        pcsrc_decode = 1'b1; pc_branch = 32'h500;

        // Reset while in DROP with a response arriving
        @(negedge clk); pcsrc_decode = 1'b0; rst = 1'b0; ready = 1'b1; #1;
        expect_bus("t6_drop", 1'b1, 32'h300);
        @(negedge clk); #1;
        expect_bus("t6_rst", 1'b0, 32'h0);
        expect_head("t6_rst", 1'b0, 32'h0, 32'h0);
        check("t6_flush", W'(flush_decode), 32'h0);
        rst = 1'b1;
        @(negedge clk); #1;
        expect_bus("t6_restart", 1'b1, 32'h0);
        @(negedge clk); #1;
        expect_bus("t6_seq", 1'b1, 32'h4);
        expect_head("t6_seq", 1'b1, 32'h4, rd(32'h0));

        // PC wraps modulo 2^32
        jump_decode = 1'b1; pc_jump = 32'hFFFF_FFF8;
        @(negedge clk); jump_decode = 1'b0; #1;
        expect_bus("t7_tgt", 1'b1, 32'hFFFF_FFF8);
        check("t7_cleared", W'(fetch_valid), 32'h0);
        @(negedge clk); #1;
        expect_bus("t7_top", 1'b1, 32'hFFFF_FFFC);
        expect_head("t7_top", 1'b1, 32'hFFFF_FFFC, rd(32'hFFFF_FFF8));
        @(negedge clk); #1;
        expect_bus("t7_wrap", 1'b1, 32'h0);
        expect_head("t7_wrap", 1'b1, 32'h0, rd(32'hFFFF_FFFC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_ctrl

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch path. It owns the program counter and drives a variable-latency instruction memory through a request/ready handshake. Returned instructions are buffered in a 2-entry fetch queue that feeds the IF/ID boundary. The block also applies branch and jump redirects from decode, discarding any stale in-flight response.

## Interface
Parameters:
- `WIDTH`, 32, address/instruction width
- `RESET_PC`, 0, first fetch address after reset

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `stall_decode`  in  1  decode cannot accept the head instruction this cycle
- `jump_decode`  in  1  jump resolved in decode
- `pcsrc_decode`  in  1  taken branch resolved in decode
- `pc_jump`  in  WIDTH  jump target
- `pc_branch`  in  WIDTH  branch target
- `imem_req`  out  1  fetch request
- `imem_addr`  out  WIDTH  fetch address; stable while `imem_req`=1
- `imem_ready`  in  1  one-cycle pulse: `imem_rdata` valid, transaction complete
- `imem_rdata`  in  WIDTH  instruction word
- `fetch_valid`  out  1  queue head valid
- `instr_fetch`  out  WIDTH  head instruction
- `pc_fetch`  out  WIDTH  head PC+4
- `flush_decode`  out  1  redirect accepted this cycle; clear IF/ID

## Operation
- `redirect` = (`jump_decode` | `pcsrc_decode`) & !`stall_decode`.
- Target selection: `pc_jump` if `jump_decode`, else `pc_branch`. Jump wins.
- `flush_decode` = `redirect` (combinational).
- `pop` = `fetch_valid` & !`stall_decode` & !`redirect`.
- Queue: 2 entries of {instr, pc+4}, with head/tail pointers and a 0..2 `count`. Push occurs on an accepted response.
- Memory contract:
  - Once raised, `imem_req` stays high with a fixed `imem_addr` until `imem_ready`.
  - Requests never overlap.
  - `imem_ready` is never back-pressured, so issue is gated on space: at most (2 − `count`) entries may be outstanding or held.
- FSM states:
  - IDLE: reset state; `imem_req`=0. Goes to WAIT after exactly one cycle. Redirects are ignored here.
  - ISSUE: `imem_req`=0; the queue is full. Goes to WAIT when `count`<2 or `pop`.
  - WAIT: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready` without a redirect: push {rdata, pc+4} and set `pc`←`pc`+4. Next state is WAIT if `count_next`<2, else ISSUE.
  - DROP: `imem_req`=1, `imem_addr` held at the stale `pc`. On `imem_ready`: discard the data, set `pc`←`pend`, go to WAIT.
- Redirect, in any non-IDLE state: the queue is cleared (`count`←0; pushes and pops that cycle are suppressed). Then:
  - ISSUE: `pc`←target, go to WAIT.
  - WAIT with `imem_ready`: discard the response, `pc`←target, go to WAIT.
  - WAIT without `imem_ready`: `pend`←target, go to DROP.
  - DROP without `imem_ready`: `pend`←target (the latest redirect wins).
  - DROP with `imem_ready`: discard, `pc`←target, go to WAIT.
- Width: all PC arithmetic is modulo 2^WIDTH. 0xFFFFFFFC wraps to 0.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, `pend`=0, `count`=0, `imem_req`=0, `imem_addr`=RESET_PC, `fetch_valid`=0, `instr_fetch`=0, `pc_fetch`=0.
- Reset asserted in any state returns to the values above on the next edge. Any in-flight memory response is ignored.
- First `imem_req` is high 1 cycle after reset release.
- Response latency: `imem_ready` at edge k gives `fetch_valid`=1 in cycle k+1.
- Zero-wait memory (`imem_ready` tied high in WAIT) sustains 1 instruction/cycle when `stall_decode`=0.
- A redirect in cycle t:
  - The target is requested from cycle t+1 (ISSUE/WAIT).
  - From DROP, the target is requested in the cycle after the stale `imem_ready`.

## Structure
- The shared defines file supplies `WIDTH` and the FSM state encodings (IDLE/ISSUE/WAIT/DROP).
- The queue is a natural sub-module: `fetch_queue` (2 entries, push/pop/clear, count, head outputs).
- The FSM, `pc`/`pend` registers and redirect logic stay in `fetch_ctrl`.

## Test plan
- Reset, then `imem_ready`=1 continuously with `stall_decode`=0 → requests to 0x0, 0x4, 0x8 on consecutive cycles. `pc_fetch` shows 0x4, 0x8, 0xC, one per cycle after the first response.
- `stall_decode`=1 held for 5 cycles with a zero-wait memory → `count` reaches 2, state goes to ISSUE, `imem_req`=0. On release, the head pops and the next request goes out to the correct sequential PC.
- 3-cycle memory latency, with `pcsrc_decode`=1 and `pc_branch`=0x40 one cycle into WAIT for 0x8 → `flush_decode` pulses, `imem_addr` stays 0x8 until ready, and that response is discarded. Next request is 0x40.
- Jump and branch asserted together (`pc_jump`=0x100, `pc_branch`=0x40) → next request is 0x100.
- Redirect in the same cycle as `imem_ready` → data is not pushed, `fetch_valid`=0, and the next request is to the target.
- `rst`=0 asserted during DROP → all outputs return to reset values, and fetching restarts at RESET_PC.
